// File: rtl/sim_mem_lat.sv
// sim_mem_lat: simulation memory for the pipelined RISC-V benches.
//
// One shared word array `mem` serves an instruction port (read-only) and a
// data port (read/write with byte enables). Both ports use a req/gnt/rvalid
// handshake. Every accepted request, including writes and erroring
// accesses, produces exactly one response `Latency` cycles later, in order.
// Grants can be withheld on a fixed schedule to exercise core stall paths.
// A data write to `TohostAddr` ends the test: it latches the exit code and
// freezes the cycle counter.
//
// Parameters
//   XLen       data/address width
//   NPos       words in `mem`
//   Latency    acceptance-to-rvalid cycles (1..8)
//   StallEvery withhold gnt one cycle in every StallEvery (0 = never)
//   TohostAddr byte address of the end-of-test register
//
// Ports
//   clk_i, rst_i                      clock, async active-high reset
//   i_req_i/i_gnt_o/i_addr_i          instruction request channel
//   i_rvalid_o/i_rdata_o/i_err_o      instruction response channel
//   d_req_i/d_gnt_o/d_addr_i          data request channel
//   d_we_i/d_be_i/d_wdata_i           data write controls
//   d_rvalid_o/d_rdata_o/d_err_o      data response channel
//   done_o, exit_code_o, cycles_o     end-of-test status
module sim_mem_lat #(
  parameter int unsigned     XLen       = 32,
  parameter int unsigned     NPos       = 1024,
  parameter int unsigned     Latency    = 1,
  parameter int unsigned     StallEvery = 0,
  parameter logic [XLen-1:0] TohostAddr = 32'h0000_0FF0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_req_i,
  output logic              i_gnt_o,
  input  logic [XLen-1:0]   i_addr_i,
  output logic              i_rvalid_o,
  output logic [XLen-1:0]   i_rdata_o,
  output logic              i_err_o,
  input  logic              d_req_i,
  output logic              d_gnt_o,
  input  logic [XLen-1:0]   d_addr_i,
  input  logic              d_we_i,
  input  logic [XLen/8-1:0] d_be_i,
  input  logic [XLen-1:0]   d_wdata_i,
  output logic              d_rvalid_o,
  output logic [XLen-1:0]   d_rdata_o,
  output logic              d_err_o,
  output logic              done_o,
  output logic [XLen-1:0]   exit_code_o,
  output logic [31:0]       cycles_o
);

  localparam int unsigned AddrWidth = $clog2(NPos) + 2;
  localparam int unsigned IdxWidth  = AddrWidth - 2;
  localparam int unsigned NBytes    = XLen / 8;
  localparam int unsigned NPorts    = 2;
  localparam int unsigned IPort     = 0;
  localparam int unsigned DPort     = 1;
  localparam int unsigned CntWidth  = (StallEvery > 2) ? $clog2(StallEvery) : 1;
  // One extra bit so the end-of-array bound cannot wrap.
  localparam logic [XLen:0] MemBytes = (XLen + 1)'(NPos) << 2;

  typedef struct packed {
    logic            valid;
    logic            err;
    logic [XLen-1:0] data;
  } rsp_t;

  logic [XLen-1:0]     mem [NPos];

  logic [NPorts-1:0]   req;
  logic [NPorts-1:0]   we;
  logic [NPorts-1:0]   gnt;
  logic [NPorts-1:0]   bad;
  logic [NPorts-1:0]   accept;
  logic [XLen-1:0]     addr   [NPorts];
  logic [IdxWidth-1:0] idx    [NPorts];
  rsp_t                rsp_in [NPorts];
  rsp_t                pipe   [NPorts][Latency];

  logic                d_write;
  logic                tohost_hit;
  logic [XLen-1:0]     d_merged;

  logic                done_q;
  logic [XLen-1:0]     exit_code_q;
  logic [31:0]         cycles_q;

  // Port 0 is the instruction port and never writes.
  assign req          = {d_req_i, i_req_i};
  assign we           = {d_we_i, 1'b0};
  assign addr[IPort]  = i_addr_i;
  assign addr[DPort]  = d_addr_i;

  always_comb begin : decode
    for (int p = 0; p < NPorts; p++) begin
      idx[p]    = addr[p][AddrWidth-1:2];
      bad[p]    = (addr[p][1:0] != 2'b00) || ({1'b0, addr[p]} >= MemBytes);
      accept[p] = req[p] && gnt[p];
    end
  end

  // Grant schedule: a per-port modulo counter; gnt is registered from the
  // counter's next value so it never depends on the request inputs.
  generate
    if (StallEvery == 0) begin : g_no_stall
      assign gnt = '1;
    end else begin : g_stall
      localparam logic [CntWidth-1:0] Last = CntWidth'(StallEvery - 1);
      logic [CntWidth-1:0] cnt     [NPorts];
      logic [CntWidth-1:0] cnt_nxt [NPorts];

      always_comb begin
        for (int p = 0; p < NPorts; p++) begin
          cnt_nxt[p] = (cnt[p] == Last) ? '0 : cnt[p] + 1'b1;
        end
      end

      // NOTE: state registers use non-blocking assignments so every
      // register samples pre-edge values regardless of block ordering.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          for (int p = 0; p < NPorts; p++) begin
            cnt[p] <= '0;
            gnt[p] <= (StallEvery != 1);
          end
        end else begin
          for (int p = 0; p < NPorts; p++) begin
            cnt[p] <= cnt_nxt[p];
            gnt[p] <= (cnt_nxt[p] != Last);
          end
        end
      end
    end
  endgenerate

  // Response entering the pipeline this edge. Writes and errors return zero
  // data; reads see `mem` before any same-edge write lands.
  always_comb begin : rsp_build
    for (int p = 0; p < NPorts; p++) begin
      rsp_in[p].valid = accept[p];
      rsp_in[p].err   = accept[p] && bad[p];
      rsp_in[p].data  = (accept[p] && !bad[p] && !we[p]) ? mem[idx[p]] : '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin : rsp_pipe
    if (rst_i) begin
      for (int p = 0; p < NPorts; p++) begin
        for (int s = 0; s < Latency; s++) begin
          pipe[p][s] <= '0;
        end
      end
    end else begin
      for (int p = 0; p < NPorts; p++) begin
        pipe[p][0] <= rsp_in[p];
        for (int s = 1; s < Latency; s++) begin
          pipe[p][s] <= pipe[p][s-1];
        end
      end
    end
  end

  assign d_write    = accept[DPort] && !bad[DPort] && d_we_i;
  assign tohost_hit = d_write && (d_addr_i == TohostAddr);

  // NOTE: the array has no reset; the bench preloads it and contents must
  // survive a mid-test reset, and it maps onto plain RAM this way.
  always_ff @(posedge clk_i) begin : mem_write
    if (d_write) begin
      for (int b = 0; b < NBytes; b++) begin
        if (d_be_i[b]) begin
          mem[idx[DPort]][8*b +: 8] <= d_wdata_i[8*b +: 8];
        end
      end
    end
  end

  // Word as it will look after the write; only the first tohost write uses it.
  always_comb begin : merge
    // NOTE: start from a full default so no path leaves the word unassigned
    // and a latch is never inferred.
    d_merged = mem[idx[DPort]];
    for (int b = 0; b < NBytes; b++) begin
      if (d_be_i[b]) begin
        d_merged[8*b +: 8] = d_wdata_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin : status
    if (rst_i) begin
      done_q      <= 1'b0;
      exit_code_q <= '0;
      cycles_q    <= '0;
    end else begin
      if (!done_q && (cycles_q != '1)) begin
        cycles_q <= cycles_q + 1'b1;
      end
      if (tohost_hit && !done_q) begin
        done_q      <= 1'b1;
        exit_code_q <= d_merged;
      end
    end
  end

  assign i_gnt_o     = gnt[IPort];
  assign d_gnt_o     = gnt[DPort];
  assign i_rvalid_o  = pipe[IPort][Latency-1].valid;
  assign i_err_o     = pipe[IPort][Latency-1].err;
  assign i_rdata_o   = pipe[IPort][Latency-1].data;
  assign d_rvalid_o  = pipe[DPort][Latency-1].valid;
  assign d_err_o     = pipe[DPort][Latency-1].err;
  assign d_rdata_o   = pipe[DPort][Latency-1].data;
  assign done_o      = done_q;
  assign exit_code_o = exit_code_q;
  assign cycles_o    = cycles_q;

endmodule

// File: tb/tb_sim_mem_lat.sv
// Directed bench for sim_mem_lat. Instance A: Latency 3, no stalls.
// Instance B: Latency 4, grant withheld every 4th cycle.
module tb_sim_mem_lat;

  localparam int          LAT_A  = 3;
  localparam int          LAT_B  = 4;
  localparam int          SE_B   = 4;
  localparam int          NPOS   = 1024;
  localparam logic [31:0] TOHOST = 32'h0000_0FF0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Instance A
  logic        a_rst;
  logic        a_i_req, a_i_gnt, a_i_rvalid, a_i_err;
  logic [31:0] a_i_addr, a_i_rdata;
  logic        a_d_req, a_d_gnt, a_d_we, a_d_rvalid, a_d_err;
  logic [3:0]  a_d_be;
  logic [31:0] a_d_addr, a_d_wdata, a_d_rdata;
  logic        a_done;
  logic [31:0] a_exit, a_cycles;

  // Instance B
  logic        b_rst;
  logic        b_i_req, b_i_gnt, b_i_rvalid, b_i_err;
  logic [31:0] b_i_addr, b_i_rdata;
  logic        b_d_req, b_d_gnt, b_d_we, b_d_rvalid, b_d_err;
  logic [3:0]  b_d_be;
  logic [31:0] b_d_addr, b_d_wdata, b_d_rdata;
  logic        b_done;
  logic [31:0] b_exit, b_cycles;

  sim_mem_lat #(.XLen(32), .NPos(NPOS), .Latency(LAT_A), .StallEvery(0),
                .TohostAddr(TOHOST)) dut_a (
    .clk_i(clk), .rst_i(a_rst),
    .i_req_i(a_i_req), .i_gnt_o(a_i_gnt), .i_addr_i(a_i_addr),
    .i_rvalid_o(a_i_rvalid), .i_rdata_o(a_i_rdata), .i_err_o(a_i_err),
    .d_req_i(a_d_req), .d_gnt_o(a_d_gnt), .d_addr_i(a_d_addr),
    .d_we_i(a_d_we), .d_be_i(a_d_be), .d_wdata_i(a_d_wdata),
    .d_rvalid_o(a_d_rvalid), .d_rdata_o(a_d_rdata), .d_err_o(a_d_err),
    .done_o(a_done), .exit_code_o(a_exit), .cycles_o(a_cycles)
  );

  sim_mem_lat #(.XLen(32), .NPos(NPOS), .Latency(LAT_B), .StallEvery(SE_B),
                .TohostAddr(TOHOST)) dut_b (
    .clk_i(clk), .rst_i(b_rst),
    .i_req_i(b_i_req), .i_gnt_o(b_i_gnt), .i_addr_i(b_i_addr),
    .i_rvalid_o(b_i_rvalid), .i_rdata_o(b_i_rdata), .i_err_o(b_i_err),
    .d_req_i(b_d_req), .d_gnt_o(b_d_gnt), .d_addr_i(b_d_addr),
    .d_we_i(b_d_we), .d_be_i(b_d_be), .d_wdata_i(b_d_wdata),
    .d_rvalid_o(b_d_rvalid), .d_rdata_o(b_d_rdata), .d_err_o(b_d_err),
    .done_o(b_done), .exit_code_o(b_exit), .cycles_o(b_cycles)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_data_op(input logic we, input logic [31:0] addr, input logic [3:0] be,
                           input logic [31:0] wdata, input logic [31:0] exp_rdata,
                           input logic exp_err, input string tag);
    check({tag, "_gnt"}, a_d_gnt, 1);
    a_d_req = 1'b1; a_d_we = we; a_d_addr = addr; a_d_be = be; a_d_wdata = wdata;
    step();
    a_d_req = 1'b0; a_d_we = 1'b0;
    for (int k = 0; k < LAT_A - 1; k++) begin
      check({tag, "_early"}, a_d_rvalid, 0);
      step();
    end
    check({tag, "_rvalid"}, a_d_rvalid, 1);
    check({tag, "_rdata"}, a_d_rdata, exp_rdata);
    check({tag, "_err"}, a_d_err, exp_err);
    step();
    check({tag, "_once"}, a_d_rvalid, 0);
  endtask

  task automatic a_instr_read(input logic [31:0] addr, input logic [31:0] exp_rdata,
                              input logic exp_err, input string tag);
    check({tag, "_gnt"}, a_i_gnt, 1);
    a_i_req = 1'b1; a_i_addr = addr;
    step();
    a_i_req = 1'b0;
    for (int k = 0; k < LAT_A - 1; k++) begin
      check({tag, "_early"}, a_i_rvalid, 0);
      step();
    end
    check({tag, "_rvalid"}, a_i_rvalid, 1);
    check({tag, "_rdata"}, a_i_rdata, exp_rdata);
    check({tag, "_err"}, a_i_err, exp_err);
    step();
    check({tag, "_once"}, a_i_rvalid, 0);
  endtask

  // Advance until both B ports are granted for the next edge (bounded).
  task automatic b_wait_gnt(input string tag);
    for (int k = 0; k < SE_B && !(b_i_gnt && b_d_gnt); k++) step();
    check({tag, "_gnt_wait"}, b_i_gnt && b_d_gnt, 1);
  endtask

  task automatic b_drain();
    b_i_req = 1'b0; b_d_req = 1'b0; b_d_we = 1'b0;
    repeat (LAT_B + 1) step();
  endtask

  logic [7:0] gnt_pat;

  initial begin
    a_rst = 1'b1; b_rst = 1'b1;
    a_i_req = 0; a_i_addr = 0; a_d_req = 0; a_d_we = 0; a_d_be = 0; a_d_addr = 0; a_d_wdata = 0;
    b_i_req = 0; b_i_addr = 0; b_d_req = 0; b_d_we = 0; b_d_be = 0; b_d_addr = 0; b_d_wdata = 0;
    gnt_pat = 8'b0111_0111;
    #2;
    // Reset values
    check("rst_a_i_gnt", a_i_gnt, 1);
    check("rst_a_d_gnt", a_d_gnt, 1);
    check("rst_a_i_rvalid", a_i_rvalid, 0);
    check("rst_a_d_rvalid", a_d_rvalid, 0);
    check("rst_a_i_rdata", a_i_rdata, 0);
    check("rst_a_d_rdata", a_d_rdata, 0);
    check("rst_a_errs", {a_i_err, a_d_err}, 0);
    check("rst_a_done", a_done, 0);
    check("rst_a_exit", a_exit, 0);
    check("rst_a_cycles", a_cycles, 0);
    check("rst_b_gnts", {b_i_gnt, b_d_gnt}, 2'b11);
    step();
    a_rst = 1'b0; b_rst = 1'b0;

    // Grant pattern on B with requests held: 1,1,1,0 repeating
    b_i_req = 1'b1; b_i_addr = 32'h0; b_d_req = 1'b1; b_d_addr = 32'h0;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("b_i_gnt_pat%0d", k), b_i_gnt, gnt_pat[k]);
      check($sformatf("b_d_gnt_pat%0d", k), b_d_gnt, gnt_pat[k]);
      step();
    end
    b_drain();

    // Preload through the data port, then latency and byte-enable tests on A
    a_data_op(1, 32'h0C, 4'hF, 32'hDEAD_BEEF, 32'h0, 0, "pre_w3");
    a_data_op(1, 32'h14, 4'hF, 32'h1122_3344, 32'h0, 0, "pre_w5");
    a_instr_read(32'h0C, 32'hDEAD_BEEF, 0, "lat3_read");
    a_data_op(1, 32'h14, 4'b0101, 32'hAABB_CCDD, 32'h0, 0, "be_write");
    a_instr_read(32'h14, 32'h11BB_33DD, 0, "be_read");
    a_data_op(1, 32'h14, 4'b0000, 32'hFFFF_FFFF, 32'h0, 0, "be0_write");
    a_data_op(0, 32'h14, 4'h0, 32'h0, 32'h11BB_33DD, 0, "be0_read");

    // Error accesses leave mem untouched
    a_data_op(1, 32'h00, 4'hF, 32'h1234_5678, 32'h0, 0, "pre_w0");
    a_data_op(1, 32'h02, 4'hF, 32'hFFFF_FFFF, 32'h0, 1, "err_misalign_w");
    a_data_op(1, 32'h1000, 4'hF, 32'hCAFE_F00D, 32'h0, 1, "err_range_w");
    a_instr_read(32'h02, 32'h0, 1, "err_misalign_r");
    a_instr_read(32'h1000, 32'h0, 1, "err_range_r");
    a_instr_read(32'h00, 32'h1234_5678, 0, "err_mem_kept");

    // Back-to-back reads give back-to-back responses
    a_i_req = 1'b1; a_i_addr = 32'h0C;
    step();
    check("b2b_gap0", a_i_rvalid, 0);
    a_i_addr = 32'h14;
    step();
    a_i_req = 1'b0;
    check("b2b_gap1", a_i_rvalid, 0);
    step();
    check("b2b_first_v", a_i_rvalid, 1);
    check("b2b_first_d", a_i_rdata, 32'hDEAD_BEEF);
    step();
    check("b2b_second_v", a_i_rvalid, 1);
    check("b2b_second_d", a_i_rdata, 32'h11BB_33DD);
    step();
    check("b2b_end", a_i_rvalid, 0);

    // Same-edge collision on B: instruction read sees the old word
    b_wait_gnt("coll_pre");
    b_d_req = 1'b1; b_d_we = 1'b1; b_d_addr = 32'h20; b_d_be = 4'hF; b_d_wdata = 32'h0;
    step();
    b_drain();
    b_wait_gnt("coll");
    b_d_req = 1'b1; b_d_we = 1'b1; b_d_addr = 32'h20; b_d_be = 4'hF; b_d_wdata = 32'h5;
    b_i_req = 1'b1; b_i_addr = 32'h20;
    step();
    b_i_req = 1'b0; b_d_req = 1'b0; b_d_we = 1'b0;
    repeat (LAT_B - 1) step();
    check("coll_i_rvalid", b_i_rvalid, 1);
    check("coll_i_rdata_old", b_i_rdata, 32'h0);
    check("coll_d_ack", b_d_rvalid, 1);
    check("coll_d_rdata", b_d_rdata, 32'h0);
    step();
    check("coll_i_once", b_i_rvalid, 0);
    b_wait_gnt("coll_rd");
    b_i_req = 1'b1; b_i_addr = 32'h20;
    step();
    b_i_req = 1'b0;
    repeat (LAT_B - 1) step();
    check("coll_new_rvalid", b_i_rvalid, 1);
    check("coll_new_rdata", b_i_rdata, 32'h5);
    b_drain();

    // Tohost on B, then reset with two reads in flight
    b_wait_gnt("b_tohost");
    b_d_req = 1'b1; b_d_we = 1'b1; b_d_addr = TOHOST; b_d_be = 4'hF; b_d_wdata = 32'h7;
    step();
    b_d_req = 1'b0; b_d_we = 1'b0;
    check("b_done", b_done, 1);
    check("b_exit", b_exit, 32'h7);
    b_drain();
    b_wait_gnt("inflight");
    b_i_req = 1'b1; b_i_addr = 32'h20; b_d_req = 1'b1; b_d_addr = 32'h20;
    step();
    b_i_req = 1'b0; b_d_req = 1'b0;
    step();
    check("inflight_pending", {b_i_rvalid, b_d_rvalid}, 2'b00);
    #2;
    b_rst = 1'b1;
    #1;
    check("mid_rst_gnts", {b_i_gnt, b_d_gnt}, 2'b11);
    check("mid_rst_rvalid", {b_i_rvalid, b_d_rvalid}, 2'b00);
    check("mid_rst_rdata", {b_i_rdata, b_d_rdata}, 64'h0);
    check("mid_rst_err", {b_i_err, b_d_err}, 2'b00);
    check("mid_rst_done", b_done, 0);
    check("mid_rst_exit", b_exit, 0);
    check("mid_rst_cycles", b_cycles, 0);
    step();
    step();
    b_rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      check($sformatf("post_rst_no_rvalid%0d", k), {b_i_rvalid, b_d_rvalid}, 2'b00);
    end

    // Tohost on A, 40 cycles after a fresh reset
    a_rst = 1'b1;
    #1;
    check("a_rst2_cycles", a_cycles, 0);
    a_rst = 1'b0;
    repeat (40) step();
    check("tohost_cycles40", a_cycles, 40);
    check("tohost_not_done", a_done, 0);
    a_d_req = 1'b1; a_d_we = 1'b1; a_d_addr = TOHOST; a_d_be = 4'hF; a_d_wdata = 32'h1;
    step();
    a_d_req = 1'b0; a_d_we = 1'b0;
    check("tohost_done", a_done, 1);
    check("tohost_exit", a_exit, 32'h1);
    check("tohost_cycles41", a_cycles, 41);
    repeat (LAT_A + 2) step();
    check("tohost_frozen", a_cycles, 41);
    a_data_op(1, TOHOST, 4'hF, 32'h3, 32'h0, 0, "tohost2");
    check("tohost2_exit", a_exit, 32'h1);
    check("tohost2_done", a_done, 1);
    check("tohost2_cycles", a_cycles, 41);
    a_instr_read(TOHOST, 32'h3, 0, "tohost_mem");
    a_instr_read(32'h0C, 32'hDEAD_BEEF, 0, "mem_survives_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
